// File: rtl/step2_mantissa_align_if.sv
// Operand and result bundle between the sign/exponent selection stage,
// the mantissa alignment stage and the significand add/subtract stage.
interface step2_mantissa_align_if;
    logic        start;
    logic [7:0]  ex_A;
    logic [7:0]  ex_B;
    logic [22:0] man_A;
    logic [22:0] man_B;
    logic        ex_compare;
    logic [26:0] man_out1;
    logic [26:0] man_out2;
    logic [7:0]  ex_out;
    logic        busy;
    logic        done;

    modport master (
        output start, ex_A, ex_B, man_A, man_B, ex_compare,
        input  man_out1, man_out2, ex_out, busy, done
    );

    modport slave (
        input  start, ex_A, ex_B, man_A, man_B, ex_compare,
        output man_out1, man_out2, ex_out, busy, done
    );
endinterface

// File: rtl/step2_mantissa_align.sv
// Mantissa alignment stage of the MAC floating-point adder.
// Builds 27-bit extended significands {hidden, fraction, G, R, S} and
// right-shifts the smaller-exponent operand by the exponent difference,
// at most 4 bit positions per cycle, folding shifted-out bits into sticky.
module step2_mantissa_align (
    input  logic                   clock,
    input  logic                   resetn,
    step2_mantissa_align_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        load_en;
    logic        shift_en;

    logic [7:0]  rem;
    logic [7:0]  rem_next;
    logic [26:0] man1_q;
    logic [26:0] man2_q;
    logic [7:0]  ex_q;

    logic        hid_a;
    logic        hid_b;
    logic [7:0]  eff_a;
    logic [7:0]  eff_b;
    logic [7:0]  diff;
    logic [26:0] sig_a;
    logic [26:0] sig_b;
    logic [26:0] sig_large;
    logic [26:0] sig_small;
    logic [7:0]  ex_large;
    logic        too_far;

    logic [2:0]  step;
    logic [26:0] step_mask;
    logic [26:0] shifted;
    logic        sticky_in;

    // Operand preparation: hidden bits, denormal effective exponents, and
    // selection of larger/smaller operand from the trusted ex_compare flag.
    always_comb begin
        hid_a     = |bus.ex_A;
        hid_b     = |bus.ex_B;
        eff_a     = (bus.ex_A == 8'd0) ? 8'd1 : bus.ex_A;
        eff_b     = (bus.ex_B == 8'd0) ? 8'd1 : bus.ex_B;
        sig_a     = {hid_a, bus.man_A, 3'b000};
        sig_b     = {hid_b, bus.man_B, 3'b000};
        sig_large = sig_a;
        sig_small = sig_b;
        ex_large  = bus.ex_A;
        diff      = eff_a - eff_b;
        if (bus.ex_compare) begin
            sig_large = sig_b;
            sig_small = sig_a;
            ex_large  = bus.ex_B;
            diff      = eff_b - eff_a;
        end
        too_far = (diff >= 8'd27);
    end

    // One shifter step: move by min(rem, 4) and OR the dropped bits into bit 0
    // so a sticky bit, once set, survives every later step.
    always_comb begin
        step      = (rem > 8'd4) ? 3'd4 : rem[2:0];
        step_mask = (27'd1 << step) - 27'd1;
        sticky_in = |(man1_q & step_mask);
        shifted   = man1_q >> step;
        shifted[0] = shifted[0] | sticky_in;
        rem_next  = rem - {5'b00000, step};
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus load/shift strobes for the datapath.
    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load_en = 1'b1;
                    if ((diff == 8'd0) || too_far) begin
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (rem_next == 8'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: captured on an accepted start, shifted while in
    // SHIFT, and otherwise held so results stay visible after DONE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rem    <= 8'd0;
            man1_q <= 27'd0;
            man2_q <= 27'd0;
            ex_q   <= 8'd0;
        end else if (load_en) begin
            rem    <= diff;
            man2_q <= sig_large;
            ex_q   <= ex_large;
            man1_q <= too_far ? {26'd0, |sig_small} : sig_small;
        end else if (shift_en) begin
            rem    <= rem_next;
            man1_q <= shifted;
        end
    end

    assign bus.man_out1 = man1_q;
    assign bus.man_out2 = man2_q;
    assign bus.ex_out   = ex_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_step2_mantissa_align.sv
// Directed self-checking bench for the mantissa alignment stage.
module tb_step2_mantissa_align;

    logic clock;
    logic resetn;
    int   checksRun;
    int   checksPassed;

    step2_mantissa_align_if bus ();

    step2_mantissa_align dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse start with the given operands and wait for done; lat is the
    // cycle count from the sampling edge to the done cycle, -1 on timeout.
    task automatic run_op(input logic [7:0] exA, input logic [22:0] manA,
                          input logic [7:0] exB, input logic [22:0] manB,
                          input logic cmp, output int lat, output int busyCnt);
        @(negedge clock);
        bus.ex_A = exA; bus.man_A = manA; bus.ex_B = exB; bus.man_B = manB;
        bus.ex_compare = cmp; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        lat = 1;
        busyCnt = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busyCnt++;
            @(negedge clock);
            lat++;
        end
        if (bus.busy) busyCnt++;
        if (!bus.done) lat = -1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.start = 1'b0; bus.ex_A = 8'h0; bus.ex_B = 8'h0;
        bus.man_A = 23'h0; bus.man_B = 23'h0; bus.ex_compare = 1'b0;
        repeat (3) @(negedge clock);
        checksRun++; if (bus.man_out1 !== 27'h0) $display("[TB] FAIL reset_man1 got %h want %h", bus.man_out1, 27'h0); else checksPassed++;
        checksRun++; if (bus.man_out2 !== 27'h0) $display("[TB] FAIL reset_man2 got %h want %h", bus.man_out2, 27'h0); else checksPassed++;
        checksRun++; if (bus.ex_out !== 8'h0) $display("[TB] FAIL reset_ex got %h want %h", bus.ex_out, 8'h0); else checksPassed++;
        checksRun++; if ({bus.busy, bus.done} !== 2'b00) $display("[TB] FAIL reset_flags got %b want %b", {bus.busy, bus.done}, 2'b00); else checksPassed++;
        resetn = 1'b1;
    endtask

    task automatic test_equal_exp();
        int lat, bc;
        run_op(8'h80, 23'h0, 8'h80, 23'h400000, 1'b1, lat, bc);
        checksRun++; if (lat !== 1) $display("[TB] FAIL eq_latency got %0d want %0d", lat, 1); else checksPassed++;
        checksRun++; if (bus.man_out1 !== 27'h4000000) $display("[TB] FAIL eq_man1 got %h want %h", bus.man_out1, 27'h4000000); else checksPassed++;
        checksRun++; if (bus.man_out2 !== 27'h6000000) $display("[TB] FAIL eq_man2 got %h want %h", bus.man_out2, 27'h6000000); else checksPassed++;
        checksRun++; if (bus.ex_out !== 8'h80) $display("[TB] FAIL eq_ex got %h want %h", bus.ex_out, 8'h80); else checksPassed++;
    endtask

    task automatic test_d5();
        int lat, bc;
        run_op(8'h80, 23'h0, 8'h85, 23'h0, 1'b1, lat, bc);
        checksRun++; if (lat !== 3) $display("[TB] FAIL d5_latency got %0d want %0d", lat, 3); else checksPassed++;
        checksRun++; if (bc !== 3) $display("[TB] FAIL d5_busy_cycles got %0d want %0d", bc, 3); else checksPassed++;
        checksRun++; if (bus.man_out1 !== 27'h0200000) $display("[TB] FAIL d5_man1 got %h want %h", bus.man_out1, 27'h0200000); else checksPassed++;
        checksRun++; if (bus.man_out2 !== 27'h4000000) $display("[TB] FAIL d5_man2 got %h want %h", bus.man_out2, 27'h4000000); else checksPassed++;
        checksRun++; if (bus.ex_out !== 8'h85) $display("[TB] FAIL d5_ex got %h want %h", bus.ex_out, 8'h85); else checksPassed++;
        @(negedge clock);
        checksRun++; if ({bus.busy, bus.done} !== 2'b00) $display("[TB] FAIL d5_after_done got %b want %b", {bus.busy, bus.done}, 2'b00); else checksPassed++;
        checksRun++; if (bus.man_out1 !== 27'h0200000) $display("[TB] FAIL d5_hold_man1 got %h want %h", bus.man_out1, 27'h0200000); else checksPassed++;
    endtask

    task automatic test_d4_sticky();
        int lat, bc;
        run_op(8'h80, 23'h000001, 8'h84, 23'h0, 1'b1, lat, bc);
        checksRun++; if (lat !== 2) $display("[TB] FAIL d4_latency got %0d want %0d", lat, 2); else checksPassed++;
        checksRun++; if (bus.man_out1 !== 27'h0400001) $display("[TB] FAIL d4_man1 got %h want %h", bus.man_out1, 27'h0400001); else checksPassed++;
    endtask

    task automatic test_denormal();
        int lat, bc;
        run_op(8'h00, 23'h000001, 8'h02, 23'h0, 1'b1, lat, bc);
        checksRun++; if (lat !== 2) $display("[TB] FAIL denorm_latency got %0d want %0d", lat, 2); else checksPassed++;
        checksRun++; if (bus.man_out1 !== 27'h0000004) $display("[TB] FAIL denorm_man1 got %h want %h", bus.man_out1, 27'h0000004); else checksPassed++;
        checksRun++; if (bus.ex_out !== 8'h02) $display("[TB] FAIL denorm_ex got %h want %h", bus.ex_out, 8'h02); else checksPassed++;
    endtask

    task automatic test_d26();
        int lat, bc;
        run_op(8'h80, 23'h400000, 8'h9A, 23'h0, 1'b1, lat, bc);
        checksRun++; if (lat !== 8) $display("[TB] FAIL d26_latency got %0d want %0d", lat, 8); else checksPassed++;
        checksRun++; if (bus.man_out1 !== 27'h0000001) $display("[TB] FAIL d26_man1 got %h want %h", bus.man_out1, 27'h0000001); else checksPassed++;
        checksRun++; if (bus.man_out2 !== 27'h4000000) $display("[TB] FAIL d26_man2 got %h want %h", bus.man_out2, 27'h4000000); else checksPassed++;
        checksRun++; if (bus.ex_out !== 8'h9A) $display("[TB] FAIL d26_ex got %h want %h", bus.ex_out, 8'h9A); else checksPassed++;
    endtask

    task automatic test_large_diff();
        int lat, bc;
        run_op(8'hA0, 23'h0, 8'h7F, 23'h000001, 1'b0, lat, bc);
        checksRun++; if (lat !== 1) $display("[TB] FAIL large_latency got %0d want %0d", lat, 1); else checksPassed++;
        checksRun++; if (bus.man_out1 !== 27'h0000001) $display("[TB] FAIL large_man1 got %h want %h", bus.man_out1, 27'h0000001); else checksPassed++;
        checksRun++; if (bus.man_out2 !== 27'h4000000) $display("[TB] FAIL large_man2 got %h want %h", bus.man_out2, 27'h4000000); else checksPassed++;
        checksRun++; if (bus.ex_out !== 8'hA0) $display("[TB] FAIL large_ex got %h want %h", bus.ex_out, 8'hA0); else checksPassed++;
    endtask

    task automatic test_d27();
        int lat, bc;
        run_op(8'h00, 23'h000005, 8'h1C, 23'h0, 1'b1, lat, bc);
        checksRun++; if (lat !== 1) $display("[TB] FAIL d27_latency got %0d want %0d", lat, 1); else checksPassed++;
        checksRun++; if (bus.man_out1 !== 27'h0000001) $display("[TB] FAIL d27_man1 got %h want %h", bus.man_out1, 27'h0000001); else checksPassed++;
        checksRun++; if (bus.ex_out !== 8'h1C) $display("[TB] FAIL d27_ex got %h want %h", bus.ex_out, 8'h1C); else checksPassed++;
    endtask

    task automatic test_start_while_busy();
        int lat, doneCount;
        logic [26:0] capMan1, capMan2;
        logic [7:0]  capEx;
        lat = 0; doneCount = 0; capMan1 = '0; capMan2 = '0; capEx = '0;
        @(negedge clock);
        bus.ex_A = 8'h80; bus.man_A = 23'h0; bus.ex_B = 8'h85; bus.man_B = 23'h0;
        bus.ex_compare = 1'b1; bus.start = 1'b1;
        @(negedge clock);
        bus.ex_A = 8'h10; bus.man_A = 23'h7FFFFF; bus.ex_B = 8'h10; bus.man_B = 23'h7FFFFF;
        bus.ex_compare = 1'b0; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        for (int c = 2; c <= 14; c++) begin
            if (bus.done) begin
                doneCount++;
                if (lat == 0) begin
                    lat = c; capMan1 = bus.man_out1; capMan2 = bus.man_out2; capEx = bus.ex_out;
                end
            end
            @(negedge clock);
        end
        checksRun++; if (doneCount !== 1) $display("[TB] FAIL busy_done_pulses got %0d want %0d", doneCount, 1); else checksPassed++;
        checksRun++; if (lat !== 3) $display("[TB] FAIL busy_latency got %0d want %0d", lat, 3); else checksPassed++;
        checksRun++; if (capMan1 !== 27'h0200000) $display("[TB] FAIL busy_man1 got %h want %h", capMan1, 27'h0200000); else checksPassed++;
        checksRun++; if (capMan2 !== 27'h4000000) $display("[TB] FAIL busy_man2 got %h want %h", capMan2, 27'h4000000); else checksPassed++;
        checksRun++; if (capEx !== 8'h85) $display("[TB] FAIL busy_ex got %h want %h", capEx, 8'h85); else checksPassed++;
        checksRun++; if (bus.man_out1 !== 27'h0200000) $display("[TB] FAIL busy_hold_man1 got %h want %h", bus.man_out1, 27'h0200000); else checksPassed++;
    endtask

    task automatic test_reset_mid_shift();
        int lat, bc;
        @(negedge clock);
        bus.ex_A = 8'h80; bus.man_A = 23'h400000; bus.ex_B = 8'h9A; bus.man_B = 23'h0;
        bus.ex_compare = 1'b1; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        checksRun++; if (bus.busy !== 1'b1) $display("[TB] FAIL rst_mid_busy_before got %b want %b", bus.busy, 1'b1); else checksPassed++;
        resetn = 1'b0;
        #1;
        checksRun++; if (bus.man_out1 !== 27'h0) $display("[TB] FAIL rst_mid_man1 got %h want %h", bus.man_out1, 27'h0); else checksPassed++;
        checksRun++; if (bus.man_out2 !== 27'h0) $display("[TB] FAIL rst_mid_man2 got %h want %h", bus.man_out2, 27'h0); else checksPassed++;
        checksRun++; if (bus.ex_out !== 8'h0) $display("[TB] FAIL rst_mid_ex got %h want %h", bus.ex_out, 8'h0); else checksPassed++;
        checksRun++; if ({bus.busy, bus.done} !== 2'b00) $display("[TB] FAIL rst_mid_flags got %b want %b", {bus.busy, bus.done}, 2'b00); else checksPassed++;
        @(negedge clock);
        resetn = 1'b1;
        run_op(8'h80, 23'h0, 8'h85, 23'h0, 1'b1, lat, bc);
        checksRun++; if (lat !== 3) $display("[TB] FAIL rst_after_latency got %0d want %0d", lat, 3); else checksPassed++;
        checksRun++; if (bus.man_out1 !== 27'h0200000) $display("[TB] FAIL rst_after_man1 got %h want %h", bus.man_out1, 27'h0200000); else checksPassed++;
        checksRun++; if (bus.ex_out !== 8'h85) $display("[TB] FAIL rst_after_ex got %h want %h", bus.ex_out, 8'h85); else checksPassed++;
    endtask

    // Scenario sequence and final summary.
    initial begin
        checksRun = 0;
        checksPassed = 0;
        test_reset();
        test_equal_exp();
        test_d5();
        test_d4_sticky();
        test_denormal();
        test_d26();
        test_large_diff();
        test_d27();
        test_start_while_busy();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
